alu_rr_arbiter: RTL and testbench

//  Shares one combinational ALU (A, B, 4-bit op -> Y) among NREQ requesters.
//  Per-requester valid/ready command ports; round-robin grant; one op in flight.

---
 rtl/alu_rr_arbiter_pkg.sv | 12 +
 rtl/rr_pick.sv | 36 +++
 rtl/alu_rr_arbiter.sv | 117 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// alu_pkg: shared state encoding, width defaults and clog2 for the ALU arbiter
package alu_pkg;
  localparam int WIDTH_D = 6;
  localparam int OPW_D = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or after ptr with wrap
//   req  in  NREQ  request vector
//   ptr  in  IW    search start index
//   gnt  out NREQ  one-hot winner (zero if no req)
//   idx  out IW    winner index (zero if no req)
module rr_pick
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic          w_found;
  int            w_j;
  logic [IW-1:0] w_s;
  always_comb begin
    gnt = '0;
    idx = '0;
    w_found = 1'b0;
    w_j = 0;
    w_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(ptr) + k) % NREQ;
      w_s = IW'(w_j);
      if (!w_found && req[w_s]) begin
        w_found = 1'b1;
        gnt[w_s] = 1'b1;
        idx = w_s;
      end
    end
  end
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one combinational ALU among NREQ requesters
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   grant_cnt  out  NREQ x 16-bit saturating accept counts (only with ALU_ARB_STATS_EN)
//   req_valid  in   per-requester command valid
//   req_a/b    in   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op     in   packed opcodes, requester i at [i*OPW +: OPW]
//   req_ready  out  one-hot grant, only in IDLE
//   alu_a/b/op out  registered operands to the ALU
//   alu_y      in   ALU result
//   rsp_valid  out  result valid, held until rsp_ready
//   rsp_ready  in   result consumer ready
//   rsp_id     out  requester owning rsp_y
//   rsp_y      out  registered ALU result
// Optional feature macro: ALU_ARB_STATS_EN
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int WIDTH  = WIDTH_D,
  parameter  int OPW    = OPW_D,
  parameter  int SETTLE = 1,
  localparam int IW     = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ALU_ARB_STATS_EN
  output logic [NREQ*16-1:0]    grant_cnt,
`endif
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [WIDTH-1:0]      alu_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [WIDTH-1:0]      rsp_y
);
  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [IW-1:0]    r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_y;
  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_acc;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req_valid),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .idx(w_idx)
  );
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_acc     = |(req_valid & req_ready);
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_y     = r_rsp_y;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_id <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_acc) begin
          r_a <= req_a[w_idx*WIDTH +: WIDTH];
          r_b <= req_b[w_idx*WIDTH +: WIDTH];
          r_op <= req_op[w_idx*OPW +: OPW];
          r_id <= w_idx;
          r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
          r_cnt <= '0;
          r_state <= EXEC;
        end
        EXEC: if (r_cnt == 3'(SETTLE - 1)) begin
          r_rsp_y <= alu_y;
          r_rsp_valid <= 1'b1;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_gc [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_gc[i] <= '0;
      else if (req_valid[i] && req_ready[i] && r_gc[i] != 16'hFFFF) r_gc[i] <= r_gc[i] + 16'd1;
    end
    assign grant_cnt[i*16 +: 16] = r_gc[i];
  end
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed self-checking bench with an A+B ALU stub
module tb_alu_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [23:0] req_a;
  logic [23:0] req_b;
  logic [15:0] req_op;
  logic [3:0]  req_ready;
  logic [5:0]  alu_a;
  logic [5:0]  alu_b;
  logic [3:0]  alu_op;
  logic [5:0]  alu_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_y;
`ifdef ALU_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif
  int n_chk = 0;
  int n_pass = 0;
  alu_rr_arbiter #(.NREQ(4), .WIDTH(6), .OPW(4), .SETTLE(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .req_ready(req_ready),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_y(alu_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_y(rsp_y)
  );
  assign alu_y = alu_a + alu_b;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b, input logic [3:0] op);
    req_a[i*6 +: 6] = a;
    req_b[i*6 +: 6] = b;
    req_op[i*4 +: 4] = op;
    req_valid[i] = 1'b1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic run_op(input int i, input logic [5:0] a, input logic [5:0] b, output logic [5:0] y, output logic [1:0] id);
    int k;
    k = 0;
    set_req(i, a, b, 4'd0);
    #1;
    while (!req_ready[i] && k < 8) begin
      tick;
      k++;
    end
    chk("grant_wait", 64'(k < 8), 64'd1);
    tick;
    req_valid[i] = 1'b0;
    k = 0;
    while (!rsp_valid && k < 8) begin
      tick;
      k++;
    end
    chk("rsp_wait", 64'(k < 8), 64'd1);
    y = rsp_y;
    id = rsp_id;
  endtask
  initial begin
    logic [5:0] y;
    logic [1:0] id;
    int seq[$];
    int cyc[$];
    req_a = '0;
    req_b = '0;
    req_op = '0;
    // 1: reset state
    do_reset;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_y", 64'(rsp_y), 64'd0);
    // 2: single op latency
    set_req(0, 6'd13, 6'd7, 4'd0);
    #1;
    chk("t2_ready", 64'(req_ready), 64'b0001);
    tick;
    req_valid = '0;
    chk("t2_exec_alu_a", 64'(alu_a), 64'd13);
    chk("t2_exec_alu_b", 64'(alu_b), 64'd7);
    chk("t2_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    tick;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_id", 64'(rsp_id), 64'd0);
    chk("t2_rsp_y", 64'(rsp_y), 64'd20);
    tick;
    chk("t2_idle", 64'(rsp_valid), 64'd0);
    chk("t2_alu_hold", 64'(alu_a), 64'd13);
    // 3: all requesters, round-robin order and spacing
    do_reset;
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 6'd10, 4'(i));
    #1;
    for (int c = 0; c < 20; c++) begin
      if (|req_ready) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) seq.push_back(i);
        cyc.push_back(c);
      end
      if (rsp_valid) chk("t3_rsp_y", 64'(rsp_y), 64'(rsp_id) + 64'd11);
      tick;
    end
    req_valid = '0;
    chk("t3_count", 64'(seq.size() >= 5), 64'd1);
    if (seq.size() >= 5) begin
      for (int j = 0; j < 5; j++) chk("t3_order", 64'(seq[j]), 64'(j % 4));
      for (int j = 1; j < 5; j++) chk("t3_spacing", 64'(cyc[j] - cyc[j-1]), 64'd3);
    end
    // 4: backpressure on response
    do_reset;
    rsp_ready = 1'b0;
    run_op(0, 6'd5, 6'd12, y, id);
    chk("t4_y", 64'(y), 64'd17);
    set_req(1, 6'd1, 6'd1, 4'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_y", 64'(rsp_y), 64'd17);
      chk("t4_hold_ready", 64'(req_ready), 64'd0);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_hs_ready", 64'(req_ready), 64'd0);
    tick;
    chk("t4_idle_valid", 64'(rsp_valid), 64'd0);
    chk("t4_idle_grant", 64'(req_ready), 64'b0010);
    req_valid = '0;
    // 5: wrap from ptr=3, then ptr=2
    do_reset;
    run_op(2, 6'd2, 6'd3, y, id);
    chk("t5_first_y", 64'(y), 64'd5);
    tick;
    set_req(1, 6'd4, 6'd4, 4'd0);
    #1;
    chk("t5_wrap_grant", 64'(req_ready), 64'b0010);
    tick;
    req_valid = '0;
    tick;
    chk("t5_rsp_id", 64'(rsp_id), 64'd1);
    chk("t5_rsp_y", 64'(rsp_y), 64'd8);
    tick;
    set_req(1, 6'd1, 6'd1, 4'd0);
    set_req(2, 6'd1, 6'd1, 4'd0);
    #1;
    chk("t5_ptr2_grant", 64'(req_ready), 64'b0100);
    req_valid = '0;
    // 6: reset during EXEC
    do_reset;
    set_req(0, 6'd9, 6'd9, 4'd3);
    tick;
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_alu_a", 64'(alu_a), 64'd0);
    chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("t6_alu_op", 64'(alu_op), 64'd0);
    chk("t6_rsp_y", 64'(rsp_y), 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd0);
`ifdef ALU_ARB_STATS_EN
    // 7: accept counters
    do_reset;
    for (int n = 0; n < 3; n++) begin
      run_op(2, 6'(n), 6'd1, y, id);
      tick;
    end
    chk("t7_cnt0", 64'(grant_cnt[15:0]), 64'd0);
    chk("t7_cnt1", 64'(grant_cnt[31:16]), 64'd0);
    chk("t7_cnt2", 64'(grant_cnt[47:32]), 64'd3);
    chk("t7_cnt3", 64'(grant_cnt[63:48]), 64'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
